// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Sequencing controller for the PC, F/D and D/X pipeline latches of the
//   5-stage core. It decodes the F/D and D/X instructions and produces latch
//   write enables and NOP-injection controls for three cases: load-use
//   stalls, taken-branch flushes and multi-cycle mult/div freezes. It also
//   drives the multdiv start handshake and keeps a saturating stall counter.
//
// Parameters
//   CNT_W       width of stall_cycles
//   MD_TIMEOUT  max cycles spent in MD_WAIT before a forced release (>= 2)
//
// Ports
//   clk           core clock, all state on rising edge
//   reset_n       synchronous active-low reset
//   fd_ir, dx_ir  instructions held in the F/D and D/X latches
//   branch_taken  X stage resolved dx_ir as a taken branch/jump
//   md_ready      multdiv result valid (single-cycle pulse)
//   pc_we, fd_we, dx_we           latch write enables
//   fd_flush, dx_flush, xm_flush  load NOP/bubble into F/D, D/X, X/M
//   md_start, md_is_div           multdiv start pulse and its op select
//   md_busy       waiting on multdiv
//   md_timeout    sticky flag, set on a forced release
//   stall_cycles  saturating count of cycles with pc_we=0
module pipeline_hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             branch_taken,
  input  logic             md_ready,
  output logic             pc_we,
  output logic             fd_we,
  output logic             dx_we,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_flush,
  output logic             md_start,
  output logic             md_is_div,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TW-1:0] MdLast = TW'(MD_TIMEOUT - 1);

  localparam logic [4:0] OpRtype = 5'b00000;
  localparam logic [4:0] OpBne   = 5'b00010;
  localparam logic [4:0] OpJr    = 5'b00100;
  localparam logic [4:0] OpAddi  = 5'b00101;
  localparam logic [4:0] OpBlt   = 5'b00110;
  localparam logic [4:0] OpSw    = 5'b00111;
  localparam logic [4:0] OpLw    = 5'b01000;
  localparam logic [4:0] AluMult = 5'b00110;
  localparam logic [4:0] AluDiv  = 5'b00111;

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t        state, stateNext;
  logic [TW-1:0] mdCnt, mdCntNext;
  logic          timeoutSet;

  // Decode
  logic [4:0] fdOp, fdRd, fdRs, fdRt;
  logic [4:0] dxOp, dxRd, dxAlu;
  logic       dxMult, dxDiv, dxLw, fdReadsDxRd, loadUse;

  assign fdOp  = fd_ir[31:27];
  assign fdRd  = fd_ir[26:22];
  assign fdRs  = fd_ir[21:17];
  assign fdRt  = fd_ir[16:12];
  assign dxOp  = dx_ir[31:27];
  assign dxRd  = dx_ir[26:22];
  assign dxAlu = dx_ir[6:2];

  assign dxMult = (dxOp == OpRtype) && (dxAlu == AluMult);
  assign dxDiv  = (dxOp == OpRtype) && (dxAlu == AluDiv);
  assign dxLw   = (dxOp == OpLw);

  logic unusedIrBits;
  assign unusedIrBits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  always_comb begin
    fdReadsDxRd = 1'b0;
    case (fdOp)
      OpRtype:      fdReadsDxRd = (fdRs == dxRd) || (fdRt == dxRd);
      OpAddi, OpLw: fdReadsDxRd = (fdRs == dxRd);
      OpSw, OpBne, OpBlt:
                    fdReadsDxRd = (fdRd == dxRd) || (fdRs == dxRd);
      OpJr:         fdReadsDxRd = (fdRd == dxRd);
      default:      fdReadsDxRd = 1'b0;
    endcase
  end

  // r0 is hardwired, so a load into it never creates a dependency
  assign loadUse = dxLw && (dxRd != 5'd0) && fdReadsDxRd;

  always_comb begin
    pc_we      = 1'b0;
    fd_we      = 1'b0;
    dx_we      = 1'b0;
    fd_flush   = 1'b0;
    dx_flush   = 1'b0;
    xm_flush   = 1'b0;
    md_start   = 1'b0;
    md_is_div  = 1'b0;
    stateNext  = state;
    mdCntNext  = mdCnt;
    timeoutSet = 1'b0;
    if (reset_n) begin
      case (state)
        RUN: begin
          pc_we = 1'b1;
          fd_we = 1'b1;
          dx_we = 1'b1;
          if (branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (dxMult || dxDiv) begin
            md_start  = 1'b1;
            md_is_div = dxDiv;
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            dx_we     = 1'b0;
            xm_flush  = 1'b1;
            stateNext = MD_WAIT;
            mdCntNext = '0;
          end else if (loadUse) begin
            pc_we    = 1'b0;
            fd_we    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (md_ready || (mdCnt == MdLast)) begin
            pc_we      = 1'b1;
            fd_we      = 1'b1;
            dx_we      = 1'b1;
            stateNext  = RUN;
            timeoutSet = !md_ready;
          end else begin
            xm_flush  = 1'b1;
            mdCntNext = mdCnt + 1'b1;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

  assign md_busy = (state == MD_WAIT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= RUN;
      mdCnt        <= '0;
      md_timeout   <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= stateNext;
      mdCnt <= mdCntNext;
      if (timeoutSet) md_timeout <= 1'b1;
      if (!pc_we && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 5;
  localparam int MDT   = 8;
  localparam int SMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      fd_ir, dx_ir;
  logic             branch_taken, md_ready;
  logic             pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush;
  logic             md_start, md_is_div, md_busy, md_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Model state
  bit mBusy;
  int mWait;
  int mStall;
  bit mTo;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MD_TIMEOUT(MDT)) dut (
    .clk(clk), .reset_n(reset_n), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .branch_taken(branch_taken), .md_ready(md_ready),
    .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we),
    .fd_flush(fd_flush), .dx_flush(dx_flush), .xm_flush(xm_flush),
    .md_start(md_start), .md_is_div(md_is_div), .md_busy(md_busy),
    .md_timeout(md_timeout), .stall_cycles(stall_cycles)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  // Does instruction ir read register r (per the source table)?
  function automatic bit reads(input logic [31:0] ir, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = ir[31:27]; rd = ir[26:22]; rs = ir[21:17]; rt = ir[16:12];
    if (r == 5'd0) return 1'b0;
    case (op)
      5'b00000:           return (r == rs) || (r == rt);
      5'b00101, 5'b01000: return r == rs;
      5'b00111, 5'b00010, 5'b00110: return (r == rd) || (r == rs);
      5'b00100:           return r == rd;
      default:            return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, compare against the model, advance the clock.
  task automatic step(input bit rst, input logic [31:0] fd, input logic [31:0] dx,
                      input bit br, input bit rdy);
    bit pc, fw, dw, ff, df, xf, st, dv, rel, isMul, isDiv;
    reset_n = rst; fd_ir = fd; dx_ir = dx; branch_taken = br; md_ready = rdy;
    #1;
    {pc, fw, dw, ff, df, xf, st, dv, rel} = '0;
    isMul = (dx[31:27] == 5'd0) && (dx[6:2] == 5'b00110);
    isDiv = (dx[31:27] == 5'd0) && (dx[6:2] == 5'b00111);
    if (rst) begin
      if (mBusy) begin
        rel = rdy || (mWait == MDT - 1);
        {pc, fw, dw} = {3{rel}};
        xf = !rel;
      end else begin
        {pc, fw, dw} = 3'b111;
        if (br) begin
          ff = 1; df = 1;
        end else if (isMul || isDiv) begin
          st = 1; dv = isDiv; {pc, fw, dw} = 3'b000; xf = 1;
        end else if (dx[31:27] == 5'b01000 && reads(fd, dx[26:22])) begin
          pc = 0; fw = 0; df = 1;
        end
      end
    end
    chk("ctrl", {22'd0, pc_we, fd_we, dx_we, fd_flush, dx_flush, xm_flush,
                 md_start, md_is_div, md_busy, md_timeout},
                {22'd0, pc, fw, dw, ff, df, xf, st, dv, mBusy, mTo});
    chk("stall_cycles", 32'(stall_cycles), 32'(mStall));
    @(posedge clk);
    if (!rst) begin
      mBusy = 0; mWait = 0; mStall = 0; mTo = 0;
    end else begin
      if (!pc && mStall < SMAX) mStall++;
      if (mBusy) begin
        if (rel) begin
          mBusy = 0;
          if (!rdy) mTo = 1;
        end else mWait++;
      end else if (st) begin
        mBusy = 1; mWait = 0;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rndIr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 9))
      0: return mk(5'b00000, a, b, c, 5'b00000);
      1: return mk(5'b00000, a, b, c, 5'b00110);
      2: return mk(5'b00000, a, b, c, 5'b00111);
      3, 4: return mk(5'b01000, a, b, 5'd0, 5'd0);
      5: return mk(5'b00111, a, b, 5'd0, 5'd0);
      6: return mk(5'b00101, a, b, 5'd0, 5'd0);
      7: return mk(5'b00010, a, b, 5'd0, 5'd0);
      8: return mk(5'b00100, a, 5'd0, 5'd0, 5'd0);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] nop, lw5, lw0, add75, add70, mul, dvi;
    nop   = 32'd0;
    lw5   = mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
    lw0   = mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
    add75 = mk(5'b00000, 5'd7, 5'd5, 5'd2, 5'd0);
    add70 = mk(5'b00000, 5'd7, 5'd0, 5'd2, 5'd0);
    mul   = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110);
    dvi   = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00111);
    mBusy = 0; mWait = 0; mStall = 0; mTo = 0;

    // Reset then idle
    step(0, nop, nop, 0, 0);
    for (int i = 0; i < 10; i++) step(1, nop, nop, 0, 0);
    chk("idle_stall", 32'(stall_cycles), 32'd0);

    // Load-use: one bubble, then r0 destination causes nothing
    step(1, add75, lw5, 0, 0);
    step(1, add75, nop, 0, 0);
    chk("lu_stall", 32'(stall_cycles), 32'd1);
    step(1, add70, lw0, 0, 0);
    chk("lu_r0_stall", 32'(stall_cycles), 32'd1);

    // Mult with md_ready in cycle 4
    step(0, nop, nop, 0, 0);
    step(1, nop, mul, 0, 0);
    for (int i = 0; i < 3; i++) step(1, nop, mul, 0, 0);
    chk("mul_busy", 32'(md_busy), 32'd1);
    step(1, nop, mul, 0, 1);
    chk("mul_stall", 32'(stall_cycles), 32'd4);
    chk("mul_done", 32'(md_busy), 32'd0);
    step(1, nop, nop, 0, 1);

    // Branch overrides load-use
    step(1, add75, lw5, 1, 0);
    chk("br_stall", 32'(stall_cycles), 32'd4);

    // Div timeout after 8 cycles
    step(0, nop, nop, 0, 0);
    step(1, nop, dvi, 0, 0);
    for (int i = 0; i < MDT; i++) step(1, nop, dvi, 0, 0);
    chk("to_flag", 32'(md_timeout), 32'd1);
    chk("to_stall", 32'(stall_cycles), 32'd8);
    for (int i = 0; i < 3; i++) step(1, nop, nop, 0, 0);
    chk("to_sticky", 32'(md_timeout), 32'd1);

    // Reset aborts MD_WAIT
    step(1, nop, mul, 0, 0);
    step(1, nop, mul, 0, 0);
    step(0, nop, mul, 0, 0);
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_to", 32'(md_timeout), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    step(1, nop, nop, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 59) != 0), rndIr(), rndIr(),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
